text_ram_arbiter: RTL
=====================

Name: text_ram_arbiter

Overview:
Shares the single-port text RAM between two requesters, cycle by cycle.
- Renderer: read-only, pixel-clock deadline, priority by default.
- Parser text path: read/write, used for character writes, erase and scroll copies.
Tags each read so its data returns only to the issuer. Bounds parser starvation with a wait counter. Sits between the parser's text-control path, the display renderer and the text RAM macro.

Parameters:
ADDR_W, 12, cell address width (80x30 = 2400 cells)
DATA_W, 32, cell word width (char code + attributes)
RAM_LAT, 1, RAM read latency in cycles (1..3)
MAX_WAIT, 8, parser wait cycles before it is forced to win one grant

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
rd_req  in  1  renderer read request, held until rd_gnt
rd_addr  in  ADDR_W  renderer address
rd_gnt  out  1  renderer grant pulse
rd_valid  out  1  renderer read data valid
pr_req  in  1  parser request, held until pr_gnt
pr_we  in  1  parser write enable
pr_addr  in  ADDR_W  parser address
pr_wdata  in  DATA_W  parser write data
pr_gnt  out  1  parser grant pulse
pr_valid  out  1  parser read data valid
rdata  out  DATA_W  read data, shared bus, qualified by rd_valid / pr_valid
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data
busy  out  1  fill engine active (0 when fill not compiled)

Behaviour:
- Reset (rst = 0, asynchronous): all outputs 0; wait counter 0; tag pipe cleared; FSM in IDLE.
- Grants are combinational from the current requests and registered state. At most one grant per cycle.
- A grant drives ram_en = 1 and the winner's we/addr/wdata onto the RAM port in the same cycle. With no grant, ram_en = ram_we = 0.
- Arbitration:
  - Renderer wins by default.
  - Parser wins when only it requests, or when both request and wait_cnt == MAX_WAIT.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle pr_req = 1 and pr_gnt = 0.
  - Clears on pr_gnt.
  - Holds when pr_req = 0.
- Requesters keep req and payload stable until the grant cycle. Deasserting req before grant is legal; the request is abandoned.
- Read return:
  - On a read grant, shift a 2-bit tag {valid, owner} into a RAM_LAT-deep pipe.
  - The tag exits exactly RAM_LAT cycles after the grant and raises rd_valid or pr_valid for one cycle.
  - rdata = ram_rdata in that cycle. Never both valids at once.
  - Writes push an invalid tag.
- Back-to-back grants (one per cycle) are fully pipelined; throughput is 1 access/cycle.
- Reset mid-operation drops in-flight tags, so no valid pulses follow reset.
- FSM states: IDLE and FILL. Without TEXT_RAM_FILL_EN only IDLE exists.

Optional Feature:
Macro TEXT_RAM_FILL_EN.
- Adds ports fill_start (in 1), fill_base (in ADDR_W), fill_count (in ADDR_W+1), fill_data (in DATA_W), fill_done (out 1).
- fill_start in IDLE: latch the operands. Count 0 pulses fill_done the next cycle and stays IDLE. Otherwise enter FILL with busy = 1.
- In FILL:
  - Renderer keeps priority.
  - Parser gets no grants; its wait_cnt still increments and saturates.
  - Each cycle without rd_req, write fill_data at base+i (modulo 2^ADDR_W wrap) and increment i.
  - After the last write, pulse fill_done, busy = 0, return to IDLE.
- fill_start while busy is ignored.
- Without the macro: ports absent, busy tied 0.

Decomposition:
- Shared package: requester-ID enum (REQ_RENDER, REQ_PARSER), read-tag struct, arbiter FSM state enum, default ADDR_W/DATA_W constants (shared with renderer and text control).
- One sub-module: text_ram_tag_pipe, a RAM_LAT-deep shift register of tags with a valid/owner decoder.

Test Plan:
1. Only pr_req, read addr 0x010, RAM holds 0xDEADBEEF -> pr_gnt same cycle; pr_valid with rdata 0xDEADBEEF RAM_LAT cycles later; rd_valid stays 0.
2. rd_req and pr_req held together, MAX_WAIT = 8 -> rd_gnt for 8 cycles, pr_gnt on the 9th, then renderer resumes; wait_cnt back to 0.
3. Alternating renderer/parser reads every cycle, RAM_LAT = 2 -> each valid pulse reaches its issuer in order, zero bubbles.
4. Parser write 0x00000041 to 0x07F, then renderer read 0x07F -> rd_valid with rdata 0x00000041.
5. rst pulled low one cycle after a read grant -> no rd_valid/pr_valid after release; all outputs 0 while in reset.
6. (TEXT_RAM_FILL_EN) fill base 0xFFE, count 4, renderer requesting on the 2nd fill cycle -> writes to 0xFFE, 0xFFF, 0x000, 0x001, one cycle stalled, fill_done 5 cycles after entering FILL; count 0 -> fill_done next cycle, no RAM writes.

Source files
------------

// File: rtl/text_ram_arbiter_pkg.sv
// text_ram_arbiter_pkg
// Shared types for the text RAM arbiter, the renderer and the text-control path:
// requester IDs, the read-return tag, the arbiter FSM states and the default
// text-RAM geometry (80x30 cells, 32-bit char+attribute words).
package text_ram_arbiter_pkg;

  localparam int TEXT_ADDR_W = 12;
  localparam int TEXT_DATA_W = 32;

  typedef enum logic {
    REQ_RENDER = 1'b0,
    REQ_PARSER = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e owner;
  } rd_tag_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } arb_state_e;

  localparam rd_tag_t TAG_NONE = '{valid: 1'b0, owner: REQ_RENDER};

endpackage

// File: rtl/text_ram_arbiter_if.sv
// text_ram_arbiter_if
// Bundles the renderer read port, the parser read/write port, the text RAM
// macro port and the optional fill-engine controls (TEXT_RAM_FILL_EN).
// Modports:
//   slave  - arbiter view (takes requests and RAM read data, drives grants,
//            valids, shared rdata, RAM strobes and busy/fill_done)
//   master - environment view (renderer, parser and RAM macro together)
interface text_ram_arbiter_if
  import text_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = TEXT_ADDR_W,
  parameter int DATA_W = TEXT_DATA_W
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic              pr_req;
  logic              pr_we;
  logic [ADDR_W-1:0] pr_addr;
  logic [DATA_W-1:0] pr_wdata;
  logic              pr_gnt;
  logic              pr_valid;
  logic [DATA_W-1:0] rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;
`ifdef TEXT_RAM_FILL_EN
  logic              fill_start;
  logic [ADDR_W-1:0] fill_base;
  logic [ADDR_W:0]   fill_count;
  logic [DATA_W-1:0] fill_data;
  logic              fill_done;
`endif

  modport slave (
    input  rd_req, rd_addr, pr_req, pr_we, pr_addr, pr_wdata, ram_rdata,
    output rd_gnt, rd_valid, pr_gnt, pr_valid, rdata,
    output ram_en, ram_we, ram_addr, ram_wdata, busy
`ifdef TEXT_RAM_FILL_EN
    , input fill_start, fill_base, fill_count, fill_data
    , output fill_done
`endif
  );

  modport master (
    output rd_req, rd_addr, pr_req, pr_we, pr_addr, pr_wdata, ram_rdata,
    input  rd_gnt, rd_valid, pr_gnt, pr_valid, rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata, busy
`ifdef TEXT_RAM_FILL_EN
    , output fill_start, fill_base, fill_count, fill_data
    , input fill_done
`endif
  );

endinterface

// File: rtl/text_ram_tag_pipe.sv
// text_ram_tag_pipe
// RAM_LAT-deep shift register of read tags. A tag pushed in the grant cycle
// reaches the output exactly RAM_LAT cycles later, in step with the RAM data.
// Ports:
//   clk, rst (async, active-low) - clock / reset, reset drops in-flight tags
//   tag_in                       - tag for this cycle (invalid when no read)
//   rd_valid / pr_valid          - decoded one-cycle return strobes
module text_ram_tag_pipe
  import text_ram_arbiter_pkg::*;
#(
  parameter int RAM_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_in,
  output logic    rd_valid,
  output logic    pr_valid
);

  rd_tag_t pipe [RAM_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RAM_LAT; i++) pipe[i] <= TAG_NONE;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign rd_valid = pipe[RAM_LAT-1].valid && (pipe[RAM_LAT-1].owner == REQ_RENDER);
  assign pr_valid = pipe[RAM_LAT-1].valid && (pipe[RAM_LAT-1].owner == REQ_PARSER);

endmodule

// File: rtl/text_ram_arbiter.sv
// text_ram_arbiter
// Cycle-by-cycle arbiter for the single-port text RAM. The renderer wins by
// default; the parser wins when alone or after MAX_WAIT lost cycles. Read data
// returns on the shared rdata bus, qualified by the issuer's valid strobe.
// Optional fill engine under macro TEXT_RAM_FILL_EN: writes fill_data to
// fill_count consecutive cells from fill_base, yielding to the renderer.
// Ports:
//   clk, rst (async, active-low)
//   bus (text_ram_arbiter_if.slave) - renderer, parser, RAM and fill signals
//
// FSM states (fill build only):
//   state   | meaning
//   ST_IDLE | normal renderer/parser arbitration
//   ST_FILL | fill engine owns idle RAM cycles, parser locked out
module text_ram_arbiter
  import text_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = TEXT_ADDR_W,
  parameter int DATA_W   = TEXT_DATA_W,
  parameter int RAM_LAT  = 1,
  parameter int MAX_WAIT = 8
) (
  input logic                clk,
  input logic                rst,
  text_ram_arbiter_if.slave  bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_max;
  logic              rd_gnt, pr_gnt;
  logic              filling, fill_wr;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_wdata;
  rd_tag_t           tag_in;
  logic              rd_valid, pr_valid;

  assign wait_max = (wait_cnt == WAIT_W'(MAX_WAIT));

  // Grants are gated by rst so every output is quiet while reset is held.
  always_comb begin
    pr_gnt  = 1'b0;
    rd_gnt  = 1'b0;
    fill_wr = 1'b0;
    if (rst) begin
      pr_gnt  = bus.pr_req && !filling && (!bus.rd_req || wait_max);
      rd_gnt  = bus.rd_req && !pr_gnt;
      fill_wr = filling && !bus.rd_req;
    end
  end

  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (rd_gnt) begin
      bus.ram_en   = 1'b1;
      bus.ram_addr = bus.rd_addr;
    end else if (pr_gnt) begin
      bus.ram_en    = 1'b1;
      bus.ram_we    = bus.pr_we;
      bus.ram_addr  = bus.pr_addr;
      bus.ram_wdata = bus.pr_we ? bus.pr_wdata : '0;
    end else if (fill_wr) begin
      bus.ram_en    = 1'b1;
      bus.ram_we    = 1'b1;
      bus.ram_addr  = fill_addr;
      bus.ram_wdata = fill_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (pr_gnt) begin
      wait_cnt <= '0;
    end else if (bus.pr_req && !wait_max) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Writes and idle cycles push an invalid tag so the pipe stays aligned.
  always_comb begin
    tag_in       = TAG_NONE;
    tag_in.valid = rd_gnt || (pr_gnt && !bus.pr_we);
    tag_in.owner = pr_gnt ? REQ_PARSER : REQ_RENDER;
  end

  text_ram_tag_pipe #(.RAM_LAT(RAM_LAT)) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .tag_in   (tag_in),
    .rd_valid (rd_valid),
    .pr_valid (pr_valid)
  );

  assign bus.rd_gnt   = rd_gnt;
  assign bus.pr_gnt   = pr_gnt;
  assign bus.rd_valid = rd_valid;
  assign bus.pr_valid = pr_valid;
  assign bus.rdata    = (rd_valid || pr_valid) ? bus.ram_rdata : '0;

`ifdef TEXT_RAM_FILL_EN
  arb_state_e        state_q, state_d;
  logic [ADDR_W:0]   fill_left;
  logic [DATA_W-1:0] fill_data_q;
  logic              fill_done_q;
  logic              fill_last;
  logic              fill_accept;

  assign filling     = (state_q == ST_FILL);
  assign fill_accept = !filling && bus.fill_start;
  assign fill_last   = fill_wr && (fill_left == (ADDR_W+1)'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (fill_accept && (bus.fill_count != '0)) state_d = ST_FILL;
      ST_FILL: if (fill_last) state_d = ST_IDLE;
    endcase
  end

  // fill_left is a down-counter of writes still owed; the address wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_addr   <= '0;
      fill_left   <= '0;
      fill_data_q <= '0;
      fill_done_q <= 1'b0;
    end else begin
      fill_done_q <= (fill_accept && (bus.fill_count == '0)) || fill_last;
      if (fill_accept) begin
        fill_addr   <= bus.fill_base;
        fill_left   <= bus.fill_count;
        fill_data_q <= bus.fill_data;
      end else if (fill_wr) begin
        fill_addr <= fill_addr + ADDR_W'(1);
        fill_left <= fill_left - (ADDR_W+1)'(1);
      end
    end
  end

  assign fill_wdata    = fill_data_q;
  assign bus.busy      = filling;
  assign bus.fill_done = fill_done_q;
`else
  assign filling    = 1'b0;
  assign fill_addr  = '0;
  assign fill_wdata = '0;
  assign bus.busy   = 1'b0;
`endif

endmodule
